// File: rtl/mopshub_elink_pkg.sv
// Shared elink framing constants, receiver state encoding and error causes,
// used by both the uplink decoder and the elink transmitter.
package mopshub_elink_pkg;

  localparam logic [7:0] ELINK_SOP  = 8'h7C;
  localparam logic [7:0] ELINK_EOP  = 8'hDC;
  localparam logic [7:0] ELINK_IDLE = 8'h3C;

  localparam int         PAYLOAD_BYTES = 10;
  localparam logic [3:0] PAYLOAD_LAST  = 4'd9;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_EOP     = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_PAD_EOP  = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_code_t;

  // Frame checksum: XOR of all payload bytes.
  function automatic logic [7:0] payload_xor(input logic [79:0] payload);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      acc = acc ^ payload[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/elink_byte_assembler.sv
// Shifts in one elink bit pair per clock and flags every fourth pair as a
// completed byte; align restarts the byte phase after a marker match.
module elink_byte_assembler (
  input  logic       clk_40_m,
  input  logic       rst,
  input  logic [1:0] rx_pair,
  input  logic       align,
  output logic [7:0] window,
  output logic [7:0] byte_data,
  output logic       byte_strobe
);

  logic [7:0] shift_reg;
  logic [1:0] phase_reg;
  logic       strobe_reg;

  // window is the byte that will sit in the shift register after this edge
  assign window      = {shift_reg[5:0], rx_pair};
  assign byte_data   = shift_reg;
  assign byte_strobe = strobe_reg;

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      shift_reg  <= 8'h00;
      phase_reg  <= 2'd0;
      strobe_reg <= 1'b0;
    end else begin
      shift_reg  <= window;
      phase_reg  <= align ? 2'd0 : phase_reg + 2'd1;
      strobe_reg <= !align && (phase_reg == 2'd3);
    end
  end

endmodule

// File: rtl/elink_uplink_decoder.sv
// Uplink elink frame decoder: hunts for SOP, collects payload, checksum and
// EOP, and hands accepted 76-bit frames to a one-entry valid/ready buffer.
module elink_uplink_decoder
  import mopshub_elink_pkg::*;
#(
  parameter logic [7:0] SOP_BYTE  = ELINK_SOP,
  parameter logic [7:0] EOP_BYTE  = ELINK_EOP,
  parameter logic [7:0] IDLE_BYTE = ELINK_IDLE
) (
  input  logic        clk_40_m,
  input  logic        rst,
  input  logic [1:0]  rx_elink2bit,
  output logic [75:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
  output logic        locked
);

  rx_state_t   state_reg, state_next;
  logic [3:0]  byte_cnt_reg, byte_cnt_next;
  logic [79:0] payload_reg;
  logic [7:0]  rx_csum_reg;
  logic [75:0] data_out_reg;
  logic        data_valid_reg;
  logic        frame_err_reg;
  err_code_t   err_code_reg;
  logic [15:0] frame_cnt_reg;
  logic [7:0]  err_cnt_reg;
  logic        locked_reg;

  logic [7:0]  window;
  logic [7:0]  byte_data;
  logic        byte_strobe;
  logic        sop_hit;
  logic        frame_done;
  logic        buf_free;
  err_code_t   verdict;
  logic        load_frame;
  logic        reject_frame;

  elink_byte_assembler u_assembler (
    .clk_40_m    (clk_40_m),
    .rst         (rst),
    .rx_pair     (rx_elink2bit),
    .align       (sop_hit),
    .window      (window),
    .byte_data   (byte_data),
    .byte_strobe (byte_strobe)
  );

  // A filler equal to the marker could never be told apart, so never lock on it
  assign sop_hit    = (state_reg == ST_HUNT) && (window == SOP_BYTE) && (SOP_BYTE != IDLE_BYTE);
  assign frame_done = (state_reg == ST_EOP) && byte_strobe;
  assign buf_free   = !data_valid_reg || data_ready;

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    case (state_reg)
      ST_HUNT: begin
        if (sop_hit) begin
          state_next    = ST_PAYLOAD;
          byte_cnt_next = 4'd0;
        end
      end
      ST_PAYLOAD: begin
        if (byte_strobe) begin
          byte_cnt_next = byte_cnt_reg + 4'd1;
          if (byte_cnt_reg == PAYLOAD_LAST) begin
            state_next = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (byte_strobe) begin
          state_next = ST_EOP;
        end
      end
      ST_EOP: begin
        if (byte_strobe) begin
          state_next = ST_HUNT;
        end
      end
      default: state_next = ST_HUNT;
    endcase
  end

  // Framing faults outrank a checksum fault; overflow only applies to good frames
  always_comb begin
    verdict = ERR_NONE;
    if ((payload_reg[79:76] != 4'h0) || (byte_data != EOP_BYTE)) begin
      verdict = ERR_PAD_EOP;
    end else if (payload_xor(payload_reg) != rx_csum_reg) begin
      verdict = ERR_CHECKSUM;
    end else if (!buf_free) begin
      verdict = ERR_OVERFLOW;
    end
  end

  assign load_frame   = frame_done && (verdict == ERR_NONE);
  assign reject_frame = frame_done && (verdict != ERR_NONE);

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state_reg    <= ST_HUNT;
      byte_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
    end
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      payload_reg    <= '0;
      rx_csum_reg    <= 8'h00;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      err_code_reg   <= ERR_NONE;
      frame_cnt_reg  <= 16'h0000;
      err_cnt_reg    <= 8'h00;
      locked_reg     <= 1'b0;
    end else begin
      frame_err_reg <= reject_frame;

      if ((state_reg == ST_PAYLOAD) && byte_strobe) begin
        payload_reg <= {payload_reg[71:0], byte_data};
      end
      if ((state_reg == ST_CHECK) && byte_strobe) begin
        rx_csum_reg <= byte_data;
      end

      if (sop_hit) begin
        locked_reg <= 1'b1;
      end else if (frame_done) begin
        locked_reg <= 1'b0;
      end

      if (load_frame) begin
        data_out_reg   <= payload_reg[75:0];
        data_valid_reg <= 1'b1;
        if (frame_cnt_reg != 16'hFFFF) begin
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
      end else if (data_valid_reg && data_ready) begin
        data_valid_reg <= 1'b0;
      end

      if (reject_frame) begin
        err_code_reg <= verdict;
        if (err_cnt_reg != 8'hFF) begin
          err_cnt_reg <= err_cnt_reg + 8'd1;
        end
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign frame_err  = frame_err_reg;
  assign err_code   = err_code_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign err_cnt    = err_cnt_reg;
  assign locked     = locked_reg;

endmodule

// File: tb/tb_elink_uplink_decoder.sv
// Self-checking bench: per-cycle frame-level reference model plus a table of
// directed frames and hand-written overflow, reset and saturation sequences.
module tb_elink_uplink_decoder;

  localparam logic [7:0] SOP  = 8'h7C;
  localparam logic [7:0] EOP  = 8'hDC;
  localparam logic [7:0] IDLE = 8'h3C;

  logic        clk_40_m = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  rx_elink2bit = 2'b00;
  logic        data_ready = 1'b0;
  logic [75:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic        locked;

  always #5 clk_40_m = ~clk_40_m;

  elink_uplink_decoder dut (
    .clk_40_m     (clk_40_m),
    .rst          (rst),
    .rx_elink2bit (rx_elink2bit),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .frame_err    (frame_err),
    .err_code     (err_code),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt),
    .locked       (locked)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: one buffered frame plus status, advanced per edge
  logic        m_valid = 1'b0;
  logic [75:0] m_data = '0;
  logic [1:0]  m_code = 2'd0;
  logic [15:0] m_fcnt = 16'h0;
  logic [7:0]  m_ecnt = 8'h0;
  logic        m_ferr = 1'b0;
  logic        m_locked = 1'b0;
  logic [79:0] m_pl = '0;
  logic [7:0]  m_cs = 8'h0;
  logic [7:0]  m_eop = 8'h0;
  int          lock_start = -1;
  int          decide_edge = -1;

  int   sop_first = -1;
  int   dv_rise = -1;
  logic ferr_seen = 1'b0;
  logic prev_dv = 1'b0;

  typedef struct {
    logic [79:0] pl;
    logic [7:0]  cs_delta;
    logic [7:0]  eop;
    int          odd;
    logic        exp_ferr;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vt [9];

  function automatic logic [7:0] xor10(input logic [79:0] pl);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 10; k++) acc = acc ^ pl[k*8 +: 8];
    return acc;
  endfunction

  task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic reject(input logic [1:0] code);
    m_ferr = 1'b1;
    m_code = code;
    if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
  endtask

  task automatic model_edge(input logic rdy, input logic rs);
    if (!rs) begin
      m_valid = 1'b0; m_data = '0; m_code = 2'd0; m_fcnt = 16'h0;
      m_ecnt = 8'h0; m_ferr = 1'b0; m_locked = 1'b0;
      lock_start = -1; decide_edge = -1;
      return;
    end
    m_ferr = 1'b0;
    if (m_valid && rdy) m_valid = 1'b0;
    if (cyc == decide_edge) begin
      m_locked = 1'b0;
      decide_edge = -1;
      if (m_pl[79:76] != 4'h0 || m_eop != EOP) reject(2'd2);
      else if (xor10(m_pl) != m_cs) reject(2'd1);
      else if (m_valid) reject(2'd3);
      else begin
        m_valid = 1'b1;
        m_data = m_pl[75:0];
        if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
      end
    end
    if (cyc == lock_start) begin
      m_locked = 1'b1;
      lock_start = -1;
    end
  endtask

  // mode: 0 never ready, 1 always ready, 2 random, 3 ready only on the decision edge
  function automatic logic get_rdy(input int mode);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'($urandom_range(0, 1));
      default: return (cyc + 1 == decide_edge);
    endcase
  endfunction

  task automatic step(input logic [1:0] pair, input int mode, input logic rs);
    logic r;
    r = get_rdy(mode);
    rx_elink2bit = pair;
    data_ready = r;
    rst = rs;
    @(posedge clk_40_m);
    cyc++;
    model_edge(r, rs);
    #1;
    chk("data_out", data_out, m_data);
    chk("data_valid", 76'(data_valid), 76'(m_valid));
    chk("frame_err", 76'(frame_err), 76'(m_ferr));
    chk("err_code", 76'(err_code), 76'(m_code));
    chk("frame_cnt", 76'(frame_cnt), 76'(m_fcnt));
    chk("err_cnt", 76'(err_cnt), 76'(m_ecnt));
    chk("locked", 76'(locked), 76'(m_locked));
    if (frame_err === 1'b1) ferr_seen = 1'b1;
    if (data_valid === 1'b1 && !prev_dv && dv_rise < 0) dv_rise = cyc;
    prev_dv = (data_valid === 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int mode);
    for (int p = 0; p < 4; p++) step(b[7-2*p -: 2], mode, 1'b1);
  endtask

  task automatic idle(input int n, input int mode);
    for (int k = 0; k < n; k++) send_byte(IDLE, mode);
  endtask

  task automatic send_frame(input logic [79:0] pl, input logic [7:0] cs, input logic [7:0] eop,
                            input int odd, input int mode, input int keep_bytes);
    logic [7:0] sop_b;
    logic [7:0] b [12];
    for (int k = 0; k < 10; k++) b[k] = pl[79-8*k -: 8];
    b[10] = cs;
    b[11] = eop;
    sop_b = SOP;
    for (int k = 0; k < odd; k++) step(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, mode, 1'b1);
    for (int p = 0; p < 4; p++) begin
      if (p == 0) sop_first = cyc + 1;
      if (p == 3) begin
        lock_start = cyc + 1;
        decide_edge = cyc + 1 + 49;
        m_pl = pl; m_cs = cs; m_eop = eop;
      end
      step(sop_b[7-2*p -: 2], mode, 1'b1);
    end
    for (int k = 0; k < keep_bytes; k++) send_byte(b[k], mode);
  endtask

  initial begin
    logic [15:0] exp_fc;
    logic [7:0]  exp_ec;
    logic [1:0]  exp_code;
    logic [75:0] exp_data;
    logic [79:0] pl_a, pl_e, pl_f, pl_g, pl_d, pl;
    logic [7:0]  cs, eop_b;

    pl_a = 80'h0001_2345_6789_ABCD_EF01;
    pl_d = 80'h0FED_CBA9_8765_4321_0F0F;
    pl_e = 80'h0A5A_5A5A_5A5A_5A5A_5A5A;
    pl_f = 80'h0C11_2233_4455_6677_8899;
    pl_g = 80'h0300_FFEE_DDCC_BBAA_9988;

    // checksum of every frame is derived from the payload XOR; cs_delta corrupts it
    vt[0] = '{pl_a, 8'h00, EOP, 0, 1'b0, 2'd0};
    vt[1] = '{pl_a, 8'h46, EOP, 0, 1'b1, 2'd1};
    vt[2] = '{80'h1001_2345_6789_ABCD_EF01, 8'h00, EOP, 0, 1'b1, 2'd2};
    vt[3] = '{pl_a, 8'h00, 8'hDD, 0, 1'b1, 2'd2};
    vt[4] = '{80'h1001_2345_6789_ABCD_EF01, 8'h05, EOP, 0, 1'b1, 2'd2};
    vt[5] = '{80'h007C_7C7C_7C7C_7C7C_7C7C, 8'h00, EOP, 0, 1'b0, 2'd0};
    vt[6] = '{pl_d, 8'h00, EOP, 1, 1'b0, 2'd0};
    vt[7] = '{pl_d, 8'h00, EOP, 3, 1'b0, 2'd0};
    vt[8] = '{pl_a, 8'h00, EOP, 2, 1'b0, 2'd0};

    for (int k = 0; k < 3; k++) step(2'b00, 0, 1'b0);
    idle(3, 1);

    exp_fc = 16'h0; exp_ec = 8'h0; exp_code = 2'd0; exp_data = '0;
    for (int i = 0; i < 9; i++) begin
      ferr_seen = 1'b0;
      dv_rise = -1;
      send_frame(vt[i].pl, xor10(vt[i].pl) ^ vt[i].cs_delta, vt[i].eop, vt[i].odd, 1, 12);
      idle(2, 1);
      if (vt[i].exp_ferr) begin
        exp_ec = exp_ec + 8'd1;
        exp_code = vt[i].exp_code;
      end else begin
        exp_fc = exp_fc + 16'd1;
        exp_data = vt[i].pl[75:0];
        chk("tbl_latency", 76'(dv_rise - sop_first), 76'd52);
      end
      chk("tbl_ferr", 76'(ferr_seen), 76'(vt[i].exp_ferr));
      chk("tbl_code", 76'(err_code), 76'(exp_code));
      chk("tbl_data", data_out, exp_data);
      chk("tbl_fcnt", 76'(frame_cnt), 76'(exp_fc));
      chk("tbl_ecnt", 76'(err_cnt), 76'(exp_ec));
      $display("vector %0d: err_pulse=%0b err_code=%0d data_out=%h frame_cnt=%0d err_cnt=%0d",
               i, ferr_seen, err_code, data_out, frame_cnt, err_cnt);
    end

    // Overflow: consumer stalled, two good frames back to back
    ferr_seen = 1'b0;
    send_frame(pl_a, xor10(pl_a), EOP, 0, 0, 12);
    send_frame(pl_e, xor10(pl_e), EOP, 0, 0, 12);
    idle(2, 0);
    chk("ovf_code", 76'(err_code), 76'd3);
    chk("ovf_data", data_out, pl_a[75:0]);
    chk("ovf_valid", 76'(data_valid), 76'd1);
    chk("ovf_pulse", 76'(ferr_seen), 76'd1);
    chk("ovf_fcnt", 76'(frame_cnt), 76'(exp_fc + 16'd1));
    chk("ovf_ecnt", 76'(err_cnt), 76'(exp_ec + 8'd1));
    step(2'b00, 1, 1'b1);
    chk("ovf_consume", 76'(data_valid), 76'd0);
    $display("overflow: err_code=%0d data_out=%h err_cnt=%0d", err_code, data_out, err_cnt);

    // Consume and completion on the same edge: the new frame must load
    send_frame(pl_f, xor10(pl_f), EOP, 0, 0, 12);
    idle(1, 0);
    ferr_seen = 1'b0;
    send_frame(pl_g, xor10(pl_g), EOP, 0, 3, 12);
    idle(2, 3);
    chk("simul_data", data_out, pl_g[75:0]);
    chk("simul_valid", 76'(data_valid), 76'd1);
    chk("simul_nopulse", 76'(ferr_seen), 76'd0);
    chk("simul_fcnt", 76'(frame_cnt), 76'(exp_fc + 16'd3));
    $display("simultaneous: data_out=%h data_valid=%0b frame_cnt=%0d", data_out, data_valid, frame_cnt);

    // Random frames, gaps, phase offsets and backpressure against the model
    for (int i = 0; i < 30; i++) begin
      pl = {$urandom(), $urandom(), 16'($urandom())};
      pl[79:76] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      cs = xor10(pl);
      if ($urandom_range(0, 5) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      eop_b = ($urandom_range(0, 7) == 0) ? 8'hDD : EOP;
      idle($urandom_range(0, 2), 2);
      send_frame(pl, cs, eop_b, $urandom_range(0, 3), 2, 12);
      $display("random %0d: payload=%h csum=%h eop=%h frame_cnt=%0d err_cnt=%0d",
               i, pl, cs, eop_b, frame_cnt, err_cnt);
    end
    idle(2, 1);

    // Reset in the middle of a frame, then the whole frame again
    send_frame(pl_a, xor10(pl_a), EOP, 0, 1, 5);
    step(2'b01, 1, 1'b0);
    step(2'b11, 1, 1'b0);
    dv_rise = -1;
    send_frame(pl_d, xor10(pl_d), EOP, 0, 1, 12);
    idle(2, 1);
    chk("rst_fcnt", 76'(frame_cnt), 76'd1);
    chk("rst_ecnt", 76'(err_cnt), 76'd0);
    chk("rst_code", 76'(err_code), 76'd0);
    chk("rst_data", data_out, pl_d[75:0]);
    chk("rst_latency", 76'(dv_rise - sop_first), 76'd52);
    $display("reset resend: data_out=%h frame_cnt=%0d", data_out, frame_cnt);

    // Error counter saturation
    for (int i = 0; i < 256; i++) send_frame(pl_a, xor10(pl_a) ^ 8'h01, EOP, 0, 1, 12);
    idle(2, 1);
    chk("sat_ecnt", 76'(err_cnt), 76'hFF);
    chk("sat_fcnt", 76'(frame_cnt), 76'd1);
    chk("sat_code", 76'(err_code), 76'd1);
    $display("saturation: err_cnt=%0d err_code=%0d", err_cnt, err_code);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
